// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: owns the PC, reads 1-cycle-latency instruction memory and buffers words for decode.
// A read is issued only when buffer room is guaranteed; redirects flush the buffer and drop any in-flight response.
module lc3_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h3000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_dout,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_npc,
    input  logic        decode_ready,
    input  logic        br_taken,
    input  logic [15:0] br_taddr,
    output logic [2:0]  fetch_count
);
    typedef enum logic [1:0] {RESET_S, RUN, FLUSH} state_t;

    localparam logic [3:0] DEPTH4 = 4'(BUF_DEPTH);
    localparam logic [1:0] LAST   = 2'(BUF_DEPTH - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_npc_q;
    logic        r_inflight;
    logic        r_kill;
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;
    logic [15:0] r_buf_instr [4];
    logic [15:0] r_buf_npc   [4];
    logic        w_xfer;
    logic        w_wr;
    logic        w_issue;
    logic [3:0]  w_pending;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign instr_valid = (r_count != 3'd0);
    assign instr       = instr_valid ? r_buf_instr[r_head] : 16'h0000;
    assign instr_npc   = instr_valid ? r_buf_npc[r_head]   : 16'h0000;
    assign fetch_count = r_count;
    assign imem_rd     = w_issue;
    assign imem_addr   = r_pc;
    assign w_xfer      = instr_valid && decode_ready;
    // Entries that will occupy the buffer once the current response lands and the head pops.
    assign w_pending   = {1'b0, r_count} + {3'b000, r_inflight} - {3'b000, w_xfer};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            RESET_S: w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
        if (br_taken) begin
            w_state_nxt = FLUSH;
        end
        w_issue = !reset && !br_taken && (w_pending < DEPTH4);
        // A response arriving during a redirect, or flagged by kill, belongs to the old stream.
        w_wr    = r_inflight && !br_taken && !((r_state == FLUSH) && r_kill);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= RESET_S;
            r_pc       <= RESET_PC;
            r_npc_q    <= 16'h0000;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_count    <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc    <= r_pc + 16'd1;
                r_npc_q <= r_pc + 16'd1;
            end
            if (br_taken) begin
                r_pc    <= br_taddr;
                r_kill  <= r_inflight;
                r_head  <= 2'd0;
                r_tail  <= 2'd0;
                r_count <= 3'd0;
            end else begin
                r_kill <= 1'b0;
                if (w_xfer) r_head <= ptr_inc(r_head);
                if (w_wr)   r_tail <= ptr_inc(r_tail);
                r_count <= r_count + {2'b00, w_wr} - {2'b00, w_xfer};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_buf_instr[r_tail] <= imem_dout;
            r_buf_npc[r_tail]   <= r_npc_q;
        end
    end
endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Bench for lc3_fetch_unit: memory returns addr^A5A5; a queue of fetched-but-unconsumed addresses predicts every output.
module tb_lc3_fetch_unit;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_dout;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_npc;
    logic        decode_ready;
    logic        br_taken;
    logic [15:0] br_taddr;
    logic [2:0]  fetch_count;

    int n_checks = 0;
    int n_pass   = 0;

    lc3_fetch_unit #(.RESET_PC(16'h3000), .BUF_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_dout(imem_dout), .instr_valid(instr_valid), .instr(instr),
        .instr_npc(instr_npc), .decode_ready(decode_ready), .br_taken(br_taken),
        .br_taddr(br_taddr), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    // Instruction memory: address sampled mid-cycle, data presented just after the edge.
    logic        mem_rd_s = 1'b0;
    logic [15:0] mem_a_s  = 16'h0;
    always @(negedge clock) begin
        mem_rd_s = imem_rd;
        mem_a_s  = imem_addr;
    end
    always @(posedge clock) begin
        #1;
        imem_dout = mem_rd_s ? (mem_a_s ^ 16'hA5A5) : 16'($urandom);
    end

    // Reference model: each entry is an address that was read and not yet consumed or flushed.
    typedef struct {
        logic [15:0] a;
        bit          arr;
    } ent_t;
    ent_t        q[$];
    logic [15:0] m_pc;

    logic [52:0] obs;
    assign obs = {imem_rd, imem_addr, instr_valid, instr, instr_npc, fetch_count};

    function automatic logic [52:0] exp_vec();
        logic        v;
        logic        rd;
        logic [15:0] hi;
        logic [15:0] hn;
        int          arr;
        int          x;
        v   = (q.size() > 0) && q[0].arr;
        arr = 0;
        foreach (q[i]) if (q[i].arr) arr++;
        x   = (v && decode_ready) ? 1 : 0;
        rd  = !reset && !br_taken && ((q.size() - x) < DEPTH);
        hi  = v ? (q[0].a ^ 16'hA5A5) : 16'h0000;
        hn  = v ? (q[0].a + 16'd1)    : 16'h0000;
        return {rd, m_pc, v, hi, hn, 3'(arr)};
    endfunction

    task automatic adv();
        bit xfer;
        bit iss;
        xfer = (q.size() > 0) && q[0].arr && decode_ready;
        iss  = !reset && !br_taken && ((q.size() - int'(xfer)) < DEPTH);
        @(posedge clock);
        if (!reset) begin
            if (xfer) void'(q.pop_front());
            if (br_taken) begin
                q.delete();
                m_pc = br_taddr;
            end else begin
                foreach (q[i]) q[i].arr = 1'b1;
                if (iss) begin
                    q.push_back('{a: m_pc, arr: 1'b0});
                    m_pc = m_pc + 16'd1;
                end
            end
        end
        #2;
    endtask

    task automatic drive(input logic rdy, input logic br, input logic [15:0] ta);
        decode_ready = rdy;
        br_taken     = br;
        br_taddr     = ta;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0);
        q.delete();
        m_pc = 16'h3000;
        #3;
        n_checks++;
        if (obs !== {1'b0, 16'h3000, 1'b0, 16'h0, 16'h0, 3'd0})
            $display("FAIL reset_values got=%h exp=%h", obs, {1'b0, 16'h3000, 1'b0, 16'h0, 16'h0, 3'd0});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            adv();
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if ({imem_rd, imem_addr} !== {1'b1, 16'h3000})
                    $display("FAIL first_read got=%b/%h exp=1/3000", imem_rd, imem_addr);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if ({instr_valid, instr, instr_npc} !== {1'b1, 16'h95A5, 16'h3001})
                    $display("FAIL first_instr got=%b/%h/%h exp=1/95a5/3001", instr_valid, instr, instr_npc);
                else n_pass++;
            end
            adv();
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL stall cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            if (i == 4) begin
                n_checks++;
                if ({fetch_count, imem_rd} !== {3'd2, 1'b0})
                    $display("FAIL stall_full got=%0d/%b exp=2/0", fetch_count, imem_rd);
                else n_pass++;
            end
            adv();
        end
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL stall_release cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            adv();
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b1, 16'h4000);
        @(negedge clock);
        n_checks++;
        if (obs !== exp_vec() || imem_rd !== 1'b0)
            $display("FAIL redirect_cycle got=%h exp=%h", obs, exp_vec());
        else n_pass++;
        adv();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL redirect_after cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if ({fetch_count, instr_valid, imem_rd, imem_addr} !== {3'd0, 1'b0, 1'b1, 16'h4000})
                    $display("FAIL redirect_flush got=%0d/%b/%b/%h exp=0/0/1/4000",
                             fetch_count, instr_valid, imem_rd, imem_addr);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if ({instr_valid, instr_npc} !== {1'b1, 16'h4001})
                    $display("FAIL redirect_npc got=%b/%h exp=1/4001", instr_valid, instr_npc);
                else n_pass++;
            end
            adv();
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ea;
        drive(1'b1, 1'b1, 16'hFFFE);
        for (int j = 0; j < 7; j++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL wrap cyc=%0d got=%h exp=%h", j, obs, exp_vec());
            else n_pass++;
            if (j >= 1 && j <= 4) begin
                ea = 16'hFFFE + 16'(j - 1);
                n_checks++;
                if ({imem_rd, imem_addr} !== {1'b1, ea})
                    $display("FAIL wrap_addr cyc=%0d got=%b/%h exp=1/%h", j, imem_rd, imem_addr, ea);
                else n_pass++;
            end
            if (j == 4) begin
                n_checks++;
                if (instr_npc !== 16'h0000) $display("FAIL wrap_npc got=%h exp=0000", instr_npc);
                else n_pass++;
            end
            adv();
            drive(1'b1, 1'b0, 16'h0);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 16'h5000);
        @(negedge clock);
        n_checks++;
        if (obs !== exp_vec() || instr_valid !== 1'b1)
            $display("FAIL br_xfer got=%h exp=%h", obs, exp_vec());
        else n_pass++;
        adv();
        drive(1'b1, 1'b1, 16'h6000);
        @(negedge clock);
        n_checks++;
        if (obs !== exp_vec() || imem_rd !== 1'b0)
            $display("FAIL br_second got=%h exp=%h", obs, exp_vec());
        else n_pass++;
        adv();
        drive(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL br_after cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if ({imem_rd, imem_addr, fetch_count} !== {1'b1, 16'h6000, 3'd0})
                    $display("FAIL br_last_wins got=%b/%h/%0d exp=1/6000/0", imem_rd, imem_addr, fetch_count);
                else n_pass++;
            end
            adv();
        end
    endtask

    task automatic test_async_reset();
        #1;
        reset = 1'b1;
        q.delete();
        m_pc = 16'h3000;
        #1;
        n_checks++;
        if (obs !== {1'b0, 16'h3000, 1'b0, 16'h0, 16'h0, 3'd0})
            $display("FAIL async_reset got=%h exp=%h", obs, {1'b0, 16'h3000, 1'b0, 16'h0, 16'h0, 3'd0});
        else n_pass++;
        adv();
        adv();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL restart cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if ({imem_rd, imem_addr, instr_valid} !== {1'b1, 16'h3000, 1'b0})
                    $display("FAIL restart_addr got=%b/%h/%b exp=1/3000/0", imem_rd, imem_addr, instr_valid);
                else n_pass++;
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 11) == 0), 16'($urandom));
            @(negedge clock);
            n_checks++;
            if (obs !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            else n_pass++;
            n_checks++;
            if (fetch_count > 3'(DEPTH)) $display("FAIL overflow cyc=%0d got=%0d max=%0d", i, fetch_count, DEPTH);
            else n_pass++;
            adv();
        end
        drive(1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
